// File: rtl/wb_loader_pkg.sv
// Shared definitions for the Wishbone configuration loader.
// Holds the frame-parser state encoding, the response status codes and the
// bit positions of the fields inside the CMD byte.
package wb_loader_pkg;

   typedef enum logic [2:0] {
      ST_CMD,
      ST_ADDR,
      ST_DATA,
      ST_BUS,
      ST_RESP
   } state_e;

   localparam logic [7:0] STATUS_OK      = 8'h00;
   localparam logic [7:0] STATUS_TIMEOUT = 8'hEE;

   localparam int CMD_WE_BIT  = 0;
   localparam int CMD_SEL_LSB = 4;

endpackage

// File: rtl/wishbone_config_loader.sv
// Wishbone classic initiator driven by a framed byte stream.
// A frame is CMD, 4 address bytes and, for writes, 4 data bytes (LSB first).
// Each frame becomes one single Wishbone cycle; a status byte (plus 4 read
// data bytes for reads) is returned on the response stream.
//
// Ports:
//   wb_clk_i, wb_rst_ni           clock, async active-low reset
//   rx_data_i/rx_valid_i/rx_ready_o   command byte stream in
//   tx_data_o/tx_valid_o/tx_ready_i   response byte stream out
//   wbm_*                         Wishbone master (cyc == stb)
//   busy_o                        high whenever not waiting for a CMD byte
//   timeout_o                     sticky, set when a cycle is aborted
module wishbone_config_loader
   import wb_loader_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 255,
   parameter int TIMEOUT_W      = 8
) (
   input  logic        wb_clk_i,
   input  logic        wb_rst_ni,
   input  logic [7:0]  rx_data_i,
   input  logic        rx_valid_i,
   output logic        rx_ready_o,
   output logic [7:0]  tx_data_o,
   output logic        tx_valid_o,
   input  logic        tx_ready_i,
   output logic        wbm_cyc_o,
   output logic        wbm_stb_o,
   output logic        wbm_we_o,
   output logic [3:0]  wbm_sel_o,
   output logic [31:0] wbm_addr_o,
   output logic [31:0] wbm_data_o,
   input  logic [31:0] wbm_data_i,
   input  logic        wbm_ack_i,
   output logic        busy_o,
   output logic        timeout_o
);

   // Counter value seen during the last permitted strobe cycle.
   localparam logic [TIMEOUT_W-1:0] TCNT_LAST = TIMEOUT_W'(TIMEOUT_CYCLES - 1);

   state_e             state_q, state_d;
   logic [1:0]         cnt_q, cnt_d;
   logic               we_q, we_d;
   logic [3:0]         sel_q, sel_d;
   logic [31:0]        addr_q, addr_d;
   logic [31:0]        wdata_q, wdata_d;
   logic [31:0]        rdata_q, rdata_d;
   logic [TIMEOUT_W-1:0] tcnt_q, tcnt_d;
   logic               data_phase_q, data_phase_d;
   logic [7:0]         tx_data_q, tx_data_d;
   logic               tx_valid_q, tx_valid_d;
   logic               stb_q, stb_d;
   logic               rx_ready_q, rx_ready_d;
   logic               busy_q, busy_d;
   logic               timeout_q, timeout_d;

   logic               rx_fire;
   logic               tx_fire;

   assign rx_fire = rx_valid_i && rx_ready_q;
   assign tx_fire = tx_valid_q && tx_ready_i;

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      we_d         = we_q;
      sel_d        = sel_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      rdata_d      = rdata_q;
      tcnt_d       = tcnt_q;
      data_phase_d = data_phase_q;
      tx_data_d    = tx_data_q;
      timeout_d    = timeout_q;

      case (state_q)
         ST_CMD: begin
            if (rx_fire) begin
               we_d    = rx_data_i[CMD_WE_BIT];
               sel_d   = rx_data_i[CMD_SEL_LSB +: 4];
               cnt_d   = 2'd0;
               state_d = ST_ADDR;
            end
         end
         ST_ADDR: begin
            if (rx_fire) begin
               addr_d = {rx_data_i, addr_q[31:8]};
               cnt_d  = cnt_q + 2'd1;
               if (cnt_q == 2'd3) begin
                  state_d = we_q ? ST_DATA : ST_BUS;
                  tcnt_d  = '0;
               end
            end
         end
         ST_DATA: begin
            if (rx_fire) begin
               wdata_d = {rx_data_i, wdata_q[31:8]};
               cnt_d   = cnt_q + 2'd1;
               if (cnt_q == 2'd3) begin
                  state_d = ST_BUS;
                  tcnt_d  = '0;
               end
            end
         end
         ST_BUS: begin
            // Ack is checked first so it wins over a coincident timeout.
            if (wbm_ack_i) begin
               rdata_d      = wbm_data_i;
               tx_data_d    = STATUS_OK;
               data_phase_d = 1'b0;
               cnt_d        = 2'd0;
               state_d      = ST_RESP;
            end else if (tcnt_q == TCNT_LAST) begin
               rdata_d      = '0;
               tx_data_d    = STATUS_TIMEOUT;
               timeout_d    = 1'b1;
               data_phase_d = 1'b0;
               cnt_d        = 2'd0;
               state_d      = ST_RESP;
            end else begin
               tcnt_d = tcnt_q + TIMEOUT_W'(1);
            end
         end
         ST_RESP: begin
            // Status goes first; reads then stream rdata out LSB first,
            // with the byte counter tracking the data bytes only.
            if (tx_fire) begin
               if (we_q || (data_phase_q && cnt_q == 2'd3)) begin
                  tx_data_d = 8'h00;
                  state_d   = ST_CMD;
               end else begin
                  if (data_phase_q) begin
                     cnt_d = cnt_q + 2'd1;
                  end
                  data_phase_d = 1'b1;
                  tx_data_d    = rdata_q[7:0];
                  rdata_d      = rdata_q >> 8;
               end
            end
         end
         default: state_d = ST_CMD;
      endcase

      // Handshake and status outputs are decoded from the next state so
      // they come straight from flops.
      stb_d      = (state_d == ST_BUS);
      tx_valid_d = (state_d == ST_RESP);
      rx_ready_d = (state_d == ST_CMD) || (state_d == ST_ADDR) || (state_d == ST_DATA);
      busy_d     = (state_d != ST_CMD);
   end

   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         state_q      <= ST_CMD;
         cnt_q        <= 2'd0;
         we_q         <= 1'b0;
         sel_q        <= 4'h0;
         addr_q       <= 32'h0;
         wdata_q      <= 32'h0;
         rdata_q      <= 32'h0;
         tcnt_q       <= '0;
         data_phase_q <= 1'b0;
         tx_data_q    <= 8'h00;
         tx_valid_q   <= 1'b0;
         stb_q        <= 1'b0;
         rx_ready_q   <= 1'b1;
         busy_q       <= 1'b0;
         timeout_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         we_q         <= we_d;
         sel_q        <= sel_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         rdata_q      <= rdata_d;
         tcnt_q       <= tcnt_d;
         data_phase_q <= data_phase_d;
         tx_data_q    <= tx_data_d;
         tx_valid_q   <= tx_valid_d;
         stb_q        <= stb_d;
         rx_ready_q   <= rx_ready_d;
         busy_q       <= busy_d;
         timeout_q    <= timeout_d;
      end
   end

   assign rx_ready_o = rx_ready_q;
   assign tx_data_o  = tx_data_q;
   assign tx_valid_o = tx_valid_q;
   assign wbm_cyc_o  = stb_q;
   assign wbm_stb_o  = stb_q;
   assign wbm_we_o   = we_q;
   assign wbm_sel_o  = sel_q;
   assign wbm_addr_o = addr_q;
   assign wbm_data_o = wdata_q;
   assign busy_o     = busy_q;
   assign timeout_o  = timeout_q;

endmodule
